irq_controller: RTL
===================

// Module: irq_controller
// PURPOSE
//  Interrupt source side of the program-counter fetch unit's interrupt interface.
//  Collects NUM_IRQ external request lines, latches rising edges as pending and applies a mask.
//  Issues a one-cycle interrupt_jump to the fetch unit, which saves the PC and jumps to 240.
//  Issues interrupt_clear_status when the decoder reports return-from-interrupt (RETI).
//  Sits between peripherals and the fetch unit, alongside the instruction decoder.
// PARAMETERS
//  NUM_IRQ   4   number of request lines; priority is fixed, index 0 highest
//  ID_W      2   width of irq_id; must be >= clog2(NUM_IRQ)
// PORTS
//  clk                     in   1        system clock
//  rst                     in   1        synchronous reset, ACTIVE-LOW
//  irq                     in   NUM_IRQ  raw request lines, level in, rising edge = request
//  cfg_we                  in   1        write cfg_mask/cfg_gie this cycle
//  cfg_mask                in   NUM_IRQ  per-line enable, 1 = enabled
//  cfg_gie                 in   1        global interrupt enable
//  cpu_enable              in   1        fetch enable currently driven to the fetch unit
//  cpu_jump_enable         in   1        decoder jump request currently driven to the fetch unit
//  reti                    in   1        decoder pulse: RETI instruction executing
//  interrupt_jump          out  1        to fetch unit: save PC, jump to vector 240
//  interrupt_clear_status  out  1        to fetch unit: restore saved PC
//  irq_id                  out  ID_W     index of the interrupt being serviced
//  pending                 out  NUM_IRQ  pending register (masked and unmasked lines)
//  in_service              out  1        high while state == SERVICE
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE, pending=0, mask=0, gie=0, irq_q=0, irq_id=0.
//   Combinational outputs are then 0.
//  Edge detect: irq_q <= irq every cycle.
//   A rising edge (irq & ~irq_q) at cycle n sets the pending bit at posedge n+1.
//   A level held high does not re-trigger.
//  Config: when cfg_we=1, mask<=cfg_mask and gie<=cfg_gie at the edge. The new value is used from the next cycle.
//  active = pending & mask; sel = lowest set index of active.
//  States: IDLE, SERVICE (1 bit).
//  IDLE: interrupt_jump = gie & |active & cpu_enable & ~cpu_jump_enable (combinational).
//   When interrupt_jump=1, at the edge: pending[sel]<=0, irq_id<=sel, state<=SERVICE.
//   Never assert interrupt_jump together with cpu_jump_enable: the fetch unit gives the interrupt
//   priority and the branch target would be lost. Hold the interrupt one or more cycles instead.
//  SERVICE: interrupt_jump=0 (no nesting).
//   interrupt_clear_status = reti (combinational). On reti, state<=IDLE at the edge.
//   New edges keep latching into pending during SERVICE.
//  The earliest next interrupt_jump is the cycle after interrupt_clear_status.
//  Simultaneous set and clear of the same pending bit (edge arrives in the jump cycle): set wins, bit stays 1.
//  reti while in IDLE: ignored, no clear_status.
//  Masked lines still latch pending and fire once unmasked, if still pending.
//  gie=0 in SERVICE does not abort service; it only blocks new jumps.
//  Reset mid-SERVICE: return to IDLE, pending dropped, no clear_status issued.
//  Latency: irq edge at cycle n with gie and mask set, the CPU free and in IDLE: interrupt_jump is high in cycle n+1.
// STRUCTURE
//  Package cpu_irq_pkg:
//   - IRQ_VECTOR = 8'd240, shared with the fetch unit
//   - state encoding localparams IDLE/SERVICE
//   - NUM_IRQ default
//  Sub-module irq_prio_enc: combinational, NUM_IRQ-bit vector -> {valid, index}, lowest index wins.
//  Rest is one always block for state, pending, mask, gie, irq_q and irq_id, plus assigns.
// TESTING
//  1 Reset: hold rst=0 with irq toggling -> all outputs 0, pending 0 after release.
//  2 Basic: gie=1, mask=4'b0010, irq[1] rises at cycle 5
//    -> pending=0010 at cycle 6; interrupt_jump=1 for exactly cycle 6; irq_id=1;
//    -> pending=0 and in_service=1 at cycle 7.
//    reti at cycle 12 -> interrupt_clear_status=1 in cycle 12; in_service=0 at cycle 13.
//  3 Priority and queue: irq[3] and irq[0] rise together, mask=1111
//    -> first jump with irq_id=0, pending=1000 remains;
//    -> after reti, the next cycle jumps with irq_id=3.
//  4 Jump conflict: pending active while cpu_jump_enable=1 for 3 cycles
//    -> interrupt_jump stays 0 for those cycles, then asserts in the first cycle cpu_jump_enable=0.
//  5 Mask/gie: irq[2] edge with mask[2]=0 -> pending[2]=1, no jump.
//    Set mask[2]=1 -> jump next cycle. Repeat with gie=0 -> no jump until gie=1.
//  6 Edge cases: reti in IDLE -> no clear_status.
//    irq[1] edge in the jump cycle of irq[1] -> pending[1] stays 1.
//    rst=0 during SERVICE -> IDLE, in_service=0.

Source files
------------

// File: rtl/irq_controller_pkg.sv
// Shared constants and state encoding for the fetch-unit interrupt source.
// Revision: 1.0
`default_nettype none

package cpu_irq_pkg;

  localparam logic [7:0] IRQ_VECTOR      = 8'd240;
  localparam int         NUM_IRQ_DEFAULT = 4;
  localparam int         ID_W_DEFAULT    = 2;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } irq_state_e;

endpackage

`default_nettype wire

// File: rtl/irq_controller_prio_enc.sv
// irq_prio_enc: fixed-priority encoder, lowest set index wins.
// Revision: 1.0
`default_nettype none

module irq_prio_enc #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req_i,
  output logic            valid_o,
  output logic [ID_W-1:0] idx_o
);

  // Scan high to low so the lowest active index is the last write.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        idx_o   = ID_W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/irq_controller.sv
// irq_controller: edge-latched, masked, fixed-priority interrupt source for the fetch unit.
// Revision: 1.0
`default_nettype none

module irq_controller
  import cpu_irq_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEFAULT,
  parameter int ID_W    = ID_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               cfg_we,
  input  logic [NUM_IRQ-1:0] cfg_mask,
  input  logic               cfg_gie,
  input  logic               cpu_enable,
  input  logic               cpu_jump_enable,
  input  logic               reti,
  output logic               interrupt_jump,
  output logic               interrupt_clear_status,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_IRQ-1:0] pending,
  output logic               in_service
);

  irq_state_e         state_q, state_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic               gie_q, gie_d;
  logic [NUM_IRQ-1:0] irq_q;
  logic [ID_W-1:0]    irq_id_q, irq_id_d;

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] active;
  logic               sel_valid;
  logic [ID_W-1:0]    sel;
  logic               jump;
  logic               clear;

  assign rise   = irq & ~irq_q;
  assign active = pending_q & mask_q;

  irq_prio_enc #(
    .N    (NUM_IRQ),
    .ID_W (ID_W)
  ) u_prio_enc (
    .req_i   (active),
    .valid_o (sel_valid),
    .idx_o   (sel)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    irq_id_d  = irq_id_q;
    mask_d    = mask_q;
    gie_d     = gie_q;
    jump      = 1'b0;
    clear     = 1'b0;

    if (cfg_we) begin
      mask_d = cfg_mask;
      gie_d  = cfg_gie;
    end

    case (state_q)
      IDLE: begin
        // Yield to a decoder jump so its branch target is not lost.
        jump = gie_q & sel_valid & cpu_enable & ~cpu_jump_enable;
        if (jump) begin
          pending_d[sel] = 1'b0;
          irq_id_d       = sel;
          state_d        = SERVICE;
        end
      end
      SERVICE: begin
        clear = reti;
        if (reti) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Applied after the clear so a same-cycle edge keeps the bit set.
    pending_d = pending_d | rise;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      mask_q    <= '0;
      gie_q     <= 1'b0;
      irq_q     <= '0;
      irq_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      gie_q     <= gie_d;
      irq_q     <= irq;
      irq_id_q  <= irq_id_d;
    end
  end

  assign interrupt_jump         = jump;
  assign interrupt_clear_status = clear;
  assign irq_id                 = irq_id_q;
  assign pending                = pending_q;
  assign in_service             = (state_q == SERVICE);

endmodule

`default_nettype wire
